// File: rtl/sreg_arbiter.sv
// rtl/sreg_arbiter.sv - round-robin owner of a shared serial-in/parallel-out shift register
// Grants one of two requesters, shifts its word in MSB-first, reads it back and flags mismatches.
module sreg_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             err,
  output logic             sreg_sinp,
  output logic             sreg_choice,
  output logic             sreg_resetsi,
  output logic             sreg_resetpo,
  input  logic [WIDTH-1:0] sreg_pout
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_CHECK, S_GAP} state_t;

  localparam int MAXC = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(WIDTH);

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] word, word_d;
  logic             id, id_d, last, last_d;

  logic             gnt0_d, gnt1_d, busy_d, done_d, done_id_d, err_d;
  logic             sinp_d, choice_d, resetsi_d, resetpo_d;
  logic [IW-1:0]    bit_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      word  <= '0;
      id    <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      word  <= word_d;
      id    <= id_d;
      last  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    word_d  = word;
    id_d    = id;
    last_d  = last;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; a lone request wins outright.
          id_d    = (req0 && req1) ? ~last : req1;
          word_d  = id_d ? data1 : data0;
          last_d  = id_d;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) state_d = S_CHECK;
        else                       cnt_d   = cnt + CW'(1);
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) state_d = S_IDLE;
        else                     cnt_d   = cnt + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are derived from the next state so every output is a flop.
  always_comb begin
    bit_idx   = IW'(WIDTH - 1) - IW'(cnt_d);
    gnt0_d    = (state_d == S_CLEAR) && !id_d;
    gnt1_d    = (state_d == S_CLEAR) && id_d;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state == S_CHECK);
    done_id_d = (state == S_CHECK) ? id : done_id;
    err_d     = (state == S_CHECK) ? (sreg_pout != word) : err;
    sinp_d    = (state_d == S_SHIFT) ? word[bit_idx] : 1'b0;
    choice_d  = (state_d == S_CHECK);
    resetsi_d = !((state_d == S_SHIFT) || (state_d == S_CHECK));
    resetpo_d = (state_d != S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      err          <= 1'b0;
      sreg_sinp    <= 1'b0;
      sreg_choice  <= 1'b0;
      sreg_resetsi <= 1'b1;
      sreg_resetpo <= 1'b1;
    end else begin
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      busy         <= busy_d;
      done         <= done_d;
      done_id      <= done_id_d;
      err          <= err_d;
      sreg_sinp    <= sinp_d;
      sreg_choice  <= choice_d;
      sreg_resetsi <= resetsi_d;
      sreg_resetpo <= resetpo_d;
    end
  end

endmodule
